// File: rtl/ram_port_arbiter_if.sv
// RAM port arbitration handshake between the CPU/DMA request side and the arbiter.
// The master drives requests; the slave (arbiter) drives grants and status.
interface ram_port_arbiter_if;
    logic       bus_arbitrate;
    logic [1:0] dma_req;
    logic       bus_ack;
    logic [1:0] dma_ack;
    logic       grant_owner;
    logic       burst_done;

    modport master (
        output bus_arbitrate,
        output dma_req,
        input  bus_ack,
        input  dma_ack,
        input  grant_owner,
        input  burst_done
    );

    modport slave (
        input  bus_arbitrate,
        input  dma_req,
        output bus_ack,
        output dma_ack,
        output grant_owner,
        output burst_done
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shared RAM port arbiter: CPU by default, bounded round-robin DMA bursts started
// only at CPU arbitration points, with a guaranteed CPU window after each burst.
module ram_port_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CPU_MIN   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    ram_port_arbiter_if.slave     bus
);

    generate
        if ((BURST_LEN < 1) || (BURST_LEN > 15) || (CPU_MIN < 1) || (CPU_MIN > 15)) begin : g_cfg_err
            $error("ram_port_arbiter: BURST_LEN and CPU_MIN must both be in 1..15");
        end
    endgenerate

    localparam logic [3:0] BURST_INIT = 4'(BURST_LEN - 1);
    localparam logic [3:0] HOLD_INIT  = 4'(CPU_MIN - 1);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_DMA  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_owner;
    logic       r_last_owner;
    logic [3:0] r_burst_cnt;
    logic [3:0] r_hold_cnt;
    logic       r_burst_done;
    logic       r_bus_ack;
    logic [1:0] r_dma_ack;

    logic w_winner;
    logic w_grant;
    logic w_release;

    // A tie goes to whoever did not own the previous burst.
    assign w_winner  = (bus.dma_req == 2'b11) ? ~r_last_owner : bus.dma_req[1];
    assign w_grant   = (r_hold_cnt == 4'd0) && bus.bus_arbitrate && (bus.dma_req != 2'b00);
    assign w_release = !bus.dma_req[r_owner] || (r_burst_cnt == 4'd0);

    // Grant outputs are registered alongside the state so that they always
    // reflect the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_CPU;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_burst_cnt  <= 4'd0;
            r_hold_cnt   <= 4'd0;
            r_burst_done <= 1'b0;
            r_bus_ack    <= 1'b1;
            r_dma_ack    <= 2'b00;
        end else begin
            case (r_state)
                S_CPU: begin
                    r_burst_done <= 1'b0;
                    if (w_grant) begin
                        r_state      <= S_DMA;
                        r_owner      <= w_winner;
                        r_last_owner <= w_winner;
                        r_burst_cnt  <= BURST_INIT;
                        r_bus_ack    <= 1'b0;
                        r_dma_ack    <= w_winner ? 2'b10 : 2'b01;
                    end else if (r_hold_cnt != 4'd0) begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                S_DMA: begin
                    if (w_release) begin
                        r_state      <= S_HOLD;
                        r_hold_cnt   <= HOLD_INIT;
                        r_burst_done <= 1'b1;
                        r_bus_ack    <= 1'b1;
                        r_dma_ack    <= 2'b00;
                    end else begin
                        r_burst_cnt <= r_burst_cnt - 4'd1;
                    end
                end
                S_HOLD: begin
                    r_burst_done <= 1'b0;
                    if (r_hold_cnt == 4'd0) begin
                        r_state <= S_CPU;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state      <= S_CPU;
                    r_burst_done <= 1'b0;
                    r_bus_ack    <= 1'b1;
                    r_dma_ack    <= 2'b00;
                end
            endcase
        end
    end

    assign bus.bus_ack     = r_bus_ack;
    assign bus.dma_ack     = r_dma_ack;
    assign bus.grant_owner = r_owner;
    assign bus.burst_done  = r_burst_done;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed scenarios with literal expectations plus a
// cycle-level ownership model compared against the DUT every cycle.
module tb_ram_port_arbiter;

    localparam int BURST_LEN = 4;
    localparam int CPU_MIN   = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    ram_port_arbiter_if bus_if ();

    ram_port_arbiter #(
        .BURST_LEN(BURST_LEN),
        .CPU_MIN  (CPU_MIN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ownership model: tracks who owns the port, how many granted cycles the
    // current burst has used, and how many CPU cycles have elapsed since the
    // last burst ended.
    bit   m_granted;
    bit   m_owner;
    bit   m_last;
    int   m_len;
    int   m_gap;
    bit   m_done;
    int   d_run;
    int   d_gap;
    bit   d_seen;

    initial begin
        forever begin
            @(posedge clk);
            if (!reset) begin
                m_granted = 1'b0;
                m_owner   = 1'b0;
                m_last    = 1'b1;
                m_len     = 0;
                m_gap     = CPU_MIN + 1;
                m_done    = 1'b0;
                d_run     = 0;
                d_gap     = 0;
                d_seen    = 1'b0;
            end else begin
                m_done = 1'b0;
                if (m_granted) begin
                    if (!bus_if.dma_req[m_owner] || m_len == BURST_LEN) begin
                        m_granted = 1'b0;
                        m_done    = 1'b1;
                        m_gap     = 1;
                    end else begin
                        m_len++;
                    end
                end else if (m_gap >= CPU_MIN + 1 && bus_if.bus_arbitrate && bus_if.dma_req != 2'b00) begin
                    if (bus_if.dma_req == 2'b11) m_owner = !m_last;
                    else                         m_owner = (bus_if.dma_req == 2'b10);
                    m_last    = m_owner;
                    m_granted = 1'b1;
                    m_len     = 1;
                end else if (m_gap < CPU_MIN + 1) begin
                    m_gap++;
                end
            end
            #2;
            chk("model_bus_ack", int'(bus_if.bus_ack), int'(!m_granted));
            chk("model_dma_ack", int'(bus_if.dma_ack),
                m_granted ? (m_owner ? 2 : 1) : 0);
            chk("model_grant_owner", int'(bus_if.grant_owner), int'(m_owner));
            chk("model_burst_done", int'(bus_if.burst_done), int'(m_done));
            chk("onehot", int'(bus_if.bus_ack) + int'(bus_if.dma_ack[0]) + int'(bus_if.dma_ack[1]), 1);
            if (reset) begin
                if (bus_if.dma_ack != 2'b00) begin
                    if (d_run == 0 && d_seen) chk("gap_min_ok", int'(d_gap >= CPU_MIN + 1), 1);
                    d_run++;
                end else begin
                    if (d_run > 0) begin
                        chk("burst_max_ok", int'(d_run <= BURST_LEN), 1);
                        d_seen = 1'b1;
                        d_gap  = 0;
                    end
                    d_run = 0;
                    d_gap++;
                end
            end
        end
    end

    int exp_seq [8] = '{1, 1, 1, 1, 0, 0, 0, 1};
    int exp_done[8] = '{0, 0, 0, 0, 1, 0, 0, 0};

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus_if.bus_arbitrate = 1'b0;
        bus_if.dma_req = 2'b00;
        step(2);
        chk("rst_bus_ack", int'(bus_if.bus_ack), 1);
        chk("rst_dma_ack", int'(bus_if.dma_ack), 0);
        chk("rst_grant_owner", int'(bus_if.grant_owner), 0);
        chk("rst_burst_done", int'(bus_if.burst_done), 0);
        reset = 1'b1;
        step(2);

        // Single full burst followed by the CPU window and a re-grant.
        bus_if.dma_req = 2'b01;
        bus_if.bus_arbitrate = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk($sformatf("full_dma_ack[%0d]", i), int'(bus_if.dma_ack), exp_seq[i]);
            chk($sformatf("full_burst_done[%0d]", i), int'(bus_if.burst_done), exp_done[i]);
        end

        // Asynchronous reset in the middle of the second burst.
        #2 reset = 1'b0;
        #1;
        chk("async_rst_bus_ack", int'(bus_if.bus_ack), 1);
        chk("async_rst_dma_ack", int'(bus_if.dma_ack), 0);
        chk("async_rst_burst_done", int'(bus_if.burst_done), 0);
        bus_if.bus_arbitrate = 1'b0;
        step(2);
        reset = 1'b1;

        // No grant without an arbitration point.
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk($sformatf("gate_dma_ack[%0d]", i), int'(bus_if.dma_ack), 0);
            chk($sformatf("gate_bus_ack[%0d]", i), int'(bus_if.bus_ack), 1);
        end
        bus_if.bus_arbitrate = 1'b1;
        step(1);
        chk("gate_release_dma_ack", int'(bus_if.dma_ack), 1);
        bus_if.dma_req = 2'b00;
        bus_if.bus_arbitrate = 1'b0;
        step(8);

        // Round robin from reset: tie goes to requester 0 first.
        reset = 1'b0;
        step(1);
        reset = 1'b1;
        bus_if.dma_req = 2'b11;
        bus_if.bus_arbitrate = 1'b1;
        for (int i = 0; i < 28; i++) begin
            int p;
            int e;
            step(1);
            p = i % 14;
            e = (p < 4) ? 1 : (p < 7) ? 0 : (p < 11) ? 2 : 0;
            chk($sformatf("rr_dma_ack[%0d]", i), int'(bus_if.dma_ack), e);
            if (e != 0) chk($sformatf("rr_grant_owner[%0d]", i), int'(bus_if.grant_owner), e - 1);
        end
        bus_if.dma_req = 2'b00;
        bus_if.bus_arbitrate = 1'b0;
        step(8);

        // Early release by requester 1 after two granted cycles.
        bus_if.dma_req = 2'b10;
        bus_if.bus_arbitrate = 1'b1;
        step(1);
        chk("early_dma_ack_c1", int'(bus_if.dma_ack), 2);
        step(1);
        chk("early_dma_ack_c2", int'(bus_if.dma_ack), 2);
        bus_if.dma_req = 2'b00;
        step(1);
        chk("early_dma_ack_end", int'(bus_if.dma_ack), 0);
        chk("early_burst_done", int'(bus_if.burst_done), 1);
        step(1);
        chk("early_burst_done_once", int'(bus_if.burst_done), 0);
        step(4);

        // Random traffic, checked only by the model and invariants.
        for (int i = 0; i < 10000; i++) begin
            bus_if.dma_req = 2'($urandom_range(0, 3));
            bus_if.bus_arbitrate = ($urandom_range(0, 3) != 0);
            step(1);
        end
        bus_if.dma_req = 2'b00;
        bus_if.bus_arbitrate = 1'b0;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
